// File: rtl/sprite_pkg.sv
// Purpose  : shared constants, bus width codes and FSM state type for the sprite frame loader.
// Latency  : n/a (package only).
// Backpres.: n/a; the sprite host bus has no stall, every write strobe is accepted.
// Contents : frame/bitmap geometry, control-register bit masks, state_t, ctrl_word().
// Config   : SPRITE_BMP_LOAD_EN adds the bitmap upload states to state_t.
package sprite_pkg;

    localparam int NUM_SPRITES = 8;    // objects per frame, one descriptor word each
    localparam int DESC_AW     = 8;    // descriptor memory word-address width
    localparam int SPR_AW      = 6;    // sprite host bus byte-address width
    localparam int CNT_W       = 4;    // wide enough for NUM_SPRITES and BMP_WORDS
    localparam int OBJ_BYTES   = 4;

    localparam logic [SPR_AW-1:0]  CTRL_ADDR = 6'd63;
    localparam logic [SPR_AW-1:0]  BMP_BASE  = 6'd32;
    localparam int                 BMP_WORDS = 7;
    localparam logic [DESC_AW-1:0] BMP_SRC   = 8'hC0;

    // spr_write_n encodings
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_IDLE = 2'b11;

    // sprite control register bits
    localparam logic [7:0] CTRL_BMP_WE  = 8'h01;
    localparam logic [7:0] CTRL_STG_RDY = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef SPRITE_BMP_LOAD_EN
        ST_BMP_OPEN,
        ST_BMP_DATA,
        ST_BMP_CLOSE,
`endif
        ST_OBJ,
        ST_COMMIT,
        ST_DONE
    } state_t;

    function automatic logic [31:0] ctrl_word(input logic [7:0] bits);
        return {24'd0, bits};
    endfunction

endpackage

// File: rtl/sprite_frame_loader_if.sv
// Purpose  : descriptor-memory read port plus sprite host-bus write port of the loader.
// Latency  : desc_data is valid exactly one cycle after desc_rd.
// Backpres.: none; both sides accept one access per cycle unconditionally.
// master = loader (drives reads and bus writes); slave = memory / sprite unit side.
interface sprite_frame_loader_if;
    import sprite_pkg::*;

    logic               desc_rd;
    logic [DESC_AW-1:0] desc_addr;
    logic [31:0]        desc_data;
    logic [SPR_AW-1:0]  spr_address;
    logic [31:0]        spr_wdata;
    logic [1:0]         spr_write_n;
    logic [1:0]         spr_read_n;

    modport master (
        output desc_rd, desc_addr, spr_address, spr_wdata, spr_write_n, spr_read_n,
        input  desc_data
    );

    modport slave (
        input  desc_rd, desc_addr, spr_address, spr_wdata, spr_write_n, spr_read_n,
        output desc_data
    );

endinterface

// File: rtl/sprite_word_pump.sv
// Purpose  : read-then-write pipeline copying count words from src (word addr) to dst (byte addr).
// Latency  : read k issued 1+k cycles after start_i, matching write one cycle after its read.
// Backpres.: none; streams one word per cycle once started.
// Ports    : start_i/count_i/src_i/dst_i launch a burst; desc_rd_o/desc_addr_o drive the memory;
//            wr_o/wr_addr_o mark the cycle the read data is on desc_data; last_o flags the final write.
module sprite_word_pump
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   count_i,
    input  logic [DESC_AW-1:0] src_i,
    input  logic [SPR_AW-1:0]  dst_i,
    output logic               desc_rd_o,
    output logic [DESC_AW-1:0] desc_addr_o,
    output logic               wr_o,
    output logic [SPR_AW-1:0]  wr_addr_o,
    output logic               last_o
);

    logic               rd_q, rd_d;
    logic [DESC_AW-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]   left_q, left_d;      // reads still to issue after the current one
    logic [SPR_AW-1:0]  dst_q, dst_d;        // destination of the read issued this cycle
    logic               wr_q, wr_d;
    logic [SPR_AW-1:0]  wr_addr_q, wr_addr_d;
    logic               last_q, last_d;

    always_comb begin
        rd_d      = rd_q;
        addr_d    = addr_q;
        left_d    = left_q;
        dst_d     = dst_q;
        // write stage simply trails the read stage by one cycle
        wr_d      = rd_q;
        wr_addr_d = dst_q;
        last_d    = rd_q && (left_q == '0);
        if (start_i) begin
            rd_d   = 1'b1;
            addr_d = src_i;
            left_d = count_i - 1'b1;
            dst_d  = dst_i;
        end else if (rd_q) begin
            addr_d = addr_q + 1'b1;          // wraps modulo 2^DESC_AW
            dst_d  = dst_q + SPR_AW'(OBJ_BYTES);
            if (left_q == '0) begin
                rd_d = 1'b0;
            end else begin
                left_d = left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q      <= 1'b0;
            addr_q    <= '0;
            left_q    <= '0;
            dst_q     <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            last_q    <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            dst_q     <= dst_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            last_q    <= last_d;
        end
    end

    assign desc_rd_o   = rd_q;
    assign desc_addr_o = addr_q;
    assign wr_o        = wr_q;
    assign wr_addr_o   = wr_addr_q;
    assign last_o      = last_q;

endmodule

// File: rtl/sprite_frame_loader.sv
// Purpose  : on a staging trigger, copies NUM_SPRITES descriptors into the sprite staging table,
//            then writes STAGING_READY to the control register.
// Latency  : trigger at T -> reads T+1.., commit write T+N+2, done pulse T+N+3.
// Backpres.: none on the bus; one extra trigger is queued while busy, further ones pulse overrun.
// Ports    : clk, rst_n (sync, active-low); user_interrupt/start triggers; frame_base;
//            bmp_reload; bus (descriptor read + sprite host bus, master); busy/done/overrun.
// Config   : SPRITE_BMP_LOAD_EN enables the bitmap upload after reset and on bmp_reload.
module sprite_frame_loader
    import sprite_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  user_interrupt,
    input  logic                  start,
    input  logic [DESC_AW-1:0]    frame_base,
    input  logic                  bmp_reload,
    sprite_frame_loader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    logic   trig;
    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   overrun_q, overrun_d;

    logic               pump_start;
    logic [CNT_W-1:0]   pump_cnt;
    logic [DESC_AW-1:0] pump_src;
    logic [SPR_AW-1:0]  pump_dst;
    logic               pump_wr;
    logic               pump_last;
    logic [SPR_AW-1:0]  pump_wr_addr;

    // both trigger sources in the same cycle collapse into one request
    assign trig = user_interrupt | start;

`ifdef SPRITE_BMP_LOAD_EN
    logic bmp_init_q, bmp_init_d;   // bitmap upload still owed since reset
`else
    logic bmp_reload_unused;
    assign bmp_reload_unused = bmp_reload;
`endif

    sprite_word_pump u_pump (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (pump_start),
        .count_i     (pump_cnt),
        .src_i       (pump_src),
        .dst_i       (pump_dst),
        .desc_rd_o   (bus.desc_rd),
        .desc_addr_o (bus.desc_addr),
        .wr_o        (pump_wr),
        .wr_addr_o   (pump_wr_addr),
        .last_o      (pump_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SPRITE_BMP_LOAD_EN
            bmp_init_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
`ifdef SPRITE_BMP_LOAD_EN
            bmp_init_q <= bmp_init_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overrun_d  = 1'b0;
        pump_start = 1'b0;
        pump_cnt   = CNT_W'(NUM_SPRITES);
        pump_src   = frame_base;
        pump_dst   = '0;
`ifdef SPRITE_BMP_LOAD_EN
        bmp_init_d = bmp_init_q;
`endif

        // Outside IDLE a trigger is queued once; a second one is dropped.
        // The hand-off states below consume the queue in the same cycle.
        if (trig && (state_q != ST_IDLE)) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
`ifdef SPRITE_BMP_LOAD_EN
                if (bmp_init_q || bmp_reload) begin
                    state_d    = ST_BMP_OPEN;
                    bmp_init_d = 1'b0;
                    pending_d  = pending_q | trig;
                end else
`endif
                if (trig) begin
                    pump_start = 1'b1;
                    state_d    = ST_OBJ;
                end
            end
`ifdef SPRITE_BMP_LOAD_EN
            ST_BMP_OPEN: begin
                pump_start = 1'b1;
                pump_cnt   = CNT_W'(BMP_WORDS);
                pump_src   = BMP_SRC;
                pump_dst   = BMP_BASE;
                state_d    = ST_BMP_DATA;
            end
            ST_BMP_DATA: begin
                if (pump_wr && pump_last) state_d = ST_BMP_CLOSE;
            end
`endif
            ST_OBJ: begin
                if (pump_wr && pump_last) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_DONE;
            end
`ifdef SPRITE_BMP_LOAD_EN
            ST_BMP_CLOSE,
`endif
            ST_DONE: begin
                // queued or fresh trigger launches the next object load right away
                if (pending_q || trig) begin
                    pump_start = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = ST_OBJ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Host bus mux: control-register byte writes come from the FSM state, word writes
    // pass desc_data straight through in the cycle it arrives.
    always_comb begin
        bus.spr_write_n = W_IDLE;
        bus.spr_address = '0;
        bus.spr_wdata   = '0;
        case (state_q)
            ST_COMMIT: begin
                bus.spr_write_n = W_BYTE;
                bus.spr_address = CTRL_ADDR;
                bus.spr_wdata   = ctrl_word(CTRL_STG_RDY);
            end
`ifdef SPRITE_BMP_LOAD_EN
            ST_BMP_OPEN: begin
                bus.spr_write_n = W_BYTE;
                bus.spr_address = CTRL_ADDR;
                bus.spr_wdata   = ctrl_word(CTRL_BMP_WE);
            end
            ST_BMP_CLOSE: begin
                bus.spr_write_n = W_BYTE;
                bus.spr_address = CTRL_ADDR;
                bus.spr_wdata   = ctrl_word(8'h00);
            end
`endif
            default: begin
                if (pump_wr) begin
                    bus.spr_write_n = W_WORD;
                    bus.spr_address = pump_wr_addr;
                    bus.spr_wdata   = bus.desc_data;
                end
            end
        endcase
    end

    assign bus.spr_read_n = 2'b11;   // loader never reads the sprite bus
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign overrun = overrun_q;

endmodule
